bench_cmd_sequencer: RTL and testbench
======================================

# bench_cmd_sequencer

Upstream command stage for the `bench` datapath unit. Accepts opcode/data/attribute commands over a valid/ready handshake and buffers them in a small FIFO. Replays each command as correctly spaced, registered control strobes (`signal_load`, `signal_init`, `signal_neg`, `signal_oe`) plus `data_in`/`attr_in`. This replaces hand-timed stimulus with a reusable, self-pacing driver.

## Interface
- `DATA_WIDTH`, 8, width of command data and `data_in`
- `ATTR_WIDTH`, 4, width of command attribute and `attr_in`
- `FIFO_DEPTH`, 4, command FIFO entries; must be a power of 2 and ≥2
- `SETTLE_CYCLES`, 10, idle cycles inserted after a LOAD or NEG strobe; ≥1
- `OE_CYCLES`, 10, cycles `signal_oe` is held for READ; ≥1

Ports:
- `clk` in 1: single clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: FIFO can accept
- `cmd_op` in 2: 0=INIT, 1=LOAD, 2=NEG, 3=READ
- `cmd_data` in DATA_WIDTH: operand
- `cmd_attr` in ATTR_WIDTH: attribute
- `signal_load`, `signal_init`, `signal_neg`, `signal_oe` out 1 each: bench controls
- `data_in` out DATA_WIDTH: bench operand
- `attr_in` out ATTR_WIDTH: bench attribute
- `busy` out 1: FIFO non-empty or FSM not in IDLE

## Operation
- Push: `cmd_valid && cmd_ready` at a rising edge writes {op,data,attr}. `cmd_ready = !full`. There is no bypass, so a push into a full FIFO is not accepted, even when a pop occurs on the same edge.
- FSM states are IDLE, STROBE, GAP, SETTLE, OUTPUT.
- IDLE: if the FIFO is non-empty, pop the head, latch `attr_in <= cmd_attr`, and drive the strobe for the op. Next state is STROBE, or OUTPUT for READ.
  - INIT: `signal_load=1`, `signal_init=1`, `data_in=cmd_data`.
  - LOAD: `signal_load=1`, `data_in=cmd_data`.
  - NEG: `signal_load=1`, `signal_neg=1`, `data_in=cmd_data`.
  - READ: `signal_oe=1`, `data_in=0`.
- STROBE lasts one cycle, then all strobes and `data_in` return to 0. INIT goes to GAP; LOAD and NEG go to SETTLE.
- GAP lasts one cycle with all strobes 0, then returns to IDLE.
- SETTLE holds all strobes 0 for SETTLE_CYCLES cycles, then returns to IDLE.
- OUTPUT holds `signal_oe=1` for OE_CYCLES cycles total, then drops `signal_oe` and returns to IDLE.
- At most one of STROBE/OUTPUT activity is present at a time; `signal_oe` is never high together with `signal_load`.
- `attr_in` holds its last latched value between commands.

## Timing
- All outputs are registered. On reset assertion, every output clears immediately to 0, `cmd_ready=1`, the FIFO empties, the FSM enters IDLE, and the counter clears.
- Latency: a command accepted at edge N into an idle, empty sequencer produces its strobe during cycle N+1 to N+2 (pop at edge N+1).
- Command pitch, from strobe start to the next strobe start:
  - INIT: 2 cycles
  - LOAD or NEG: 1+SETTLE_CYCLES
  - READ: OE_CYCLES
- Back-to-back commands queued in the FIFO issue with no extra bubble beyond the pitch.
- Reset mid-command aborts immediately: no residual strobe, and queued commands are lost.
- `cmd_op` is sampled only on accepted pushes; values on non-accepted cycles are ignored.

## Configuration
- `BENCH_SEQ_STATS_EN` defined: adds output `issued_count` [15:0], which increments by 1 on every pop. It saturates at 16'hFFFF and clears on reset.
- `BENCH_SEQ_STATS_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `bench_pkg` holds:
  - opcode localparams OP_INIT, OP_LOAD, OP_NEG, OP_READ
  - the FSM state encoding
  - the command record width (2+DATA_WIDTH+ATTR_WIDTH)
- Sub-module `bench_cmd_fifo`: synchronous FIFO with parameterised width/depth, full/empty flags, wrap-around pointers with an extra MSB, and async active-low reset.
- Sequencer FSM, down-counter and output registers live in `bench_cmd_sequencer`.

## Test plan
- INIT 25 → after exactly one acceptance edge, one cycle with `signal_load=1`, `signal_init=1`, `data_in=25`; then ≥1 all-zero cycle.
- INIT 25, LOAD 25, READ pushed back-to-back:
  - load strobe with `data_in=25` starts 2 cycles after the init strobe
  - `signal_oe` rises 11 cycles after the load strobe and stays high for 10 cycles
  - `busy` falls the cycle after `signal_oe` falls
- Five pushes with FIFO_DEPTH=4 while the FSM is stalled in SETTLE → `cmd_ready=0` after the 4th accept; the 5th is held until a pop frees a slot, and all 5 issue in order.
- NEG 3 with `cmd_attr=4'hA` → one cycle with `signal_load=1`, `signal_neg=1`, `data_in=3`; `attr_in=4'hA` persists through the next READ.
- `RST_N` driven low during READ's OUTPUT → `signal_oe` falls without waiting for a clock, FIFO empty, and `cmd_ready=1` after release.
- With `BENCH_SEQ_STATS_EN` defined: 6 commands → `issued_count=6`. Without the macro, the elaborated design has no `issued_count` port.

Source files
------------

// File: rtl/bench_pkg.sv
// Shared opcodes, FSM state encoding and command record sizing for the bench
// command sequencer.
package bench_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_INIT = 2'd0;
  localparam logic [OP_W-1:0] OP_LOAD = 2'd1;
  localparam logic [OP_W-1:0] OP_NEG  = 2'd2;
  localparam logic [OP_W-1:0] OP_READ = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP,
    ST_SETTLE,
    ST_OUTPUT
  } seq_state_t;

  // Stored command record is {op, data, attr}.
  function automatic int cmd_rec_w(input int data_w, input int attr_w);
    return OP_W + data_w + attr_w;
  endfunction

endpackage

// File: rtl/bench_cmd_fifo.sv
// Synchronous FIFO with full/empty flags and extra-MSB wrap pointers.
// Storage is not reset; only the pointers are.
module bench_cmd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bench_cmd_sequencer.sv
// Buffers bench commands and replays them as registered, self-paced strobes.
// Optional BENCH_SEQ_STATS_EN adds a saturating issued_count output.
module bench_cmd_sequencer
  import bench_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ATTR_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 10,
  parameter int OE_CYCLES     = 10
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ATTR_WIDTH-1:0] cmd_attr,
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  output logic                  busy
`ifdef BENCH_SEQ_STATS_EN
  ,
  output logic [15:0]           issued_count
`endif
);

  localparam int REC_W   = cmd_rec_w(DATA_WIDTH, ATTR_WIDTH);
  localparam int CNT_MAX = (SETTLE_CYCLES > OE_CYCLES) ? SETTLE_CYCLES : OE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [REC_W-1:0]      wr_rec;
  logic [REC_W-1:0]      rd_rec;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [OP_W-1:0]       head_op;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ATTR_WIDTH-1:0] head_attr;

  seq_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [OP_W-1:0]       op_q, op_nxt;
  logic                  free;
  logic                  load_nxt, init_nxt, neg_nxt, oe_nxt, busy_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [ATTR_WIDTH-1:0] attr_nxt;

  assign wr_rec    = {cmd_op, cmd_data, cmd_attr};
  assign head_op   = rd_rec[REC_W-1 -: OP_W];
  assign head_data = rd_rec[ATTR_WIDTH +: DATA_WIDTH];
  assign head_attr = rd_rec[ATTR_WIDTH-1:0];
  assign cmd_ready = !fifo_full;

  bench_cmd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (RST_N),
    .push    (cmd_valid),
    .pop     (pop),
    .wr_data (wr_rec),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    free      = 1'b0;
    pop       = 1'b0;
    load_nxt  = 1'b0;
    init_nxt  = 1'b0;
    neg_nxt   = 1'b0;
    oe_nxt    = 1'b0;
    data_nxt  = '0;
    attr_nxt  = attr_in;
    busy_nxt  = !fifo_empty || (state != ST_IDLE);

    // The last cycle of every wait doubles as the dispatch slot, so queued
    // commands follow each other at exactly the command pitch.
    case (state)
      ST_IDLE:   free = 1'b1;
      ST_STROBE: begin
        if (op_q == OP_INIT) begin
          state_nxt = ST_GAP;
        end else begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES);
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
        free      = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          free      = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          free      = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          oe_nxt  = 1'b1;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase

    if (free && !fifo_empty) begin
      pop      = 1'b1;
      op_nxt   = head_op;
      attr_nxt = head_attr;
      if (head_op == OP_READ) begin
        oe_nxt    = 1'b1;
        cnt_nxt   = CNT_W'(OE_CYCLES);
        state_nxt = ST_OUTPUT;
      end else begin
        load_nxt  = 1'b1;
        init_nxt  = (head_op == OP_INIT);
        neg_nxt   = (head_op == OP_NEG);
        data_nxt  = head_data;
        state_nxt = ST_STROBE;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= OP_INIT;
      signal_load <= 1'b0;
      signal_init <= 1'b0;
      signal_neg  <= 1'b0;
      signal_oe   <= 1'b0;
      data_in     <= '0;
      attr_in     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_q        <= op_nxt;
      signal_load <= load_nxt;
      signal_init <= init_nxt;
      signal_neg  <= neg_nxt;
      signal_oe   <= oe_nxt;
      data_in     <= data_nxt;
      attr_in     <= attr_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef BENCH_SEQ_STATS_EN
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      issued_count <= '0;
    end else if (pop && (issued_count != 16'hFFFF)) begin
      issued_count <= issued_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bench_cmd_sequencer.sv
// Self-checking bench for bench_cmd_sequencer: vector table, directed timing
// sequences and random traffic against a command-schedule reference model.
module tb_bench_cmd_sequencer;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 10;
  localparam int OE     = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_attr = '0;
  logic          signal_load, signal_init, signal_neg, signal_oe;
  logic [DW-1:0] data_in;
  logic [AW-1:0] attr_in;
  logic          busy;
`ifdef BENCH_SEQ_STATS_EN
  logic [15:0]   issued_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  bench_cmd_sequencer #(
    .DATA_WIDTH    (DW),
    .ATTR_WIDTH    (AW),
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .OE_CYCLES     (OE)
  ) dut (
    .clk          (clk),
    .RST_N        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_attr     (cmd_attr),
    .signal_load  (signal_load),
    .signal_init  (signal_init),
    .signal_neg   (signal_neg),
    .signal_oe    (signal_oe),
    .data_in      (data_in),
    .attr_in      (attr_in),
    .busy         (busy)
`ifdef BENCH_SEQ_STATS_EN
    ,
    .issued_count (issued_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: commands are popped from a queue no earlier than the
  // edge after they were accepted and no earlier than the previous command's
  // start plus its pitch.
  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          mc;
  int            k = 0, t_free = 0, last_pop = 0, oe_until = 0, cnt_before = 0;
  logic          e_load = 0, e_init = 0, e_neg = 0, e_oe = 0, e_busy = 0, e_ready = 1;
  logic [DW-1:0] e_data = '0;
  logic [AW-1:0] e_attr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      k = 0; t_free = 0; last_pop = 0; oe_until = 0;
      e_load = 0; e_init = 0; e_neg = 0; e_oe = 0; e_busy = 0; e_ready = 1;
      e_data = '0; e_attr = '0;
    end else begin
      cnt_before = mq.size();
      e_busy = (cnt_before > 0) || (k > last_pop && k <= t_free);
      e_load = 0; e_init = 0; e_neg = 0; e_data = '0;
      if (k >= t_free && cnt_before > 0) begin
        mc = mq.pop_front();
        e_attr = mc.a;
        last_pop = k;
        if (mc.op == 2'd3) begin
          oe_until = k + OE;
          t_free   = k + OE;
        end else begin
          e_load = 1;
          e_init = (mc.op == 2'd0);
          e_neg  = (mc.op == 2'd2);
          e_data = mc.d;
          t_free = k + ((mc.op == 2'd0) ? 2 : 1 + SETTLE);
        end
      end
      e_oe = (k < oe_until);
      if (cmd_valid && cnt_before < DEPTH) mq.push_back('{cmd_op, cmd_data, cmd_attr});
      e_ready = (mq.size() < DEPTH);
      k++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ({signal_load, signal_init, signal_neg, signal_oe, data_in, attr_in, busy, cmd_ready} !==
          {e_load, e_init, e_neg, e_oe, e_data, e_attr, e_busy, e_ready}) begin
        miscompares++;
        $display("FAIL model t=%0t ld/in/ng/oe=%b%b%b%b d=%0h a=%0h bsy=%b rdy=%b, expected %b%b%b%b d=%0h a=%0h bsy=%b rdy=%b",
                 $time, signal_load, signal_init, signal_neg, signal_oe, data_in, attr_in, busy, cmd_ready,
                 e_load, e_init, e_neg, e_oe, e_data, e_attr, e_busy, e_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
    bit done = 0;
    cmd_valid = 1; cmd_op = op; cmd_data = d; cmd_attr = a;
    for (int i = 0; i < 100 && !done; i++) begin
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    cmd_valid = 0;
    chk("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [3:0]    e_sig;   // {load, init, neg, oe}
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t tbl[5];

  int            t_init, t_load, t_oe, t_oef, t_bf, n, any_strobe;
  logic [DW-1:0] d_init, d_load;
  logic [DW-1:0] got[5];
  logic [DW-1:0] want[5];
  logic          acc;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'd0, 8'd25,  4'h1, 4'b1100, 8'd25};
    tbl[1] = '{2'd1, 8'hC3,  4'h2, 4'b1000, 8'hC3};
    tbl[2] = '{2'd2, 8'd3,   4'hA, 4'b1010, 8'd3};
    tbl[3] = '{2'd3, 8'h7E,  4'h5, 4'b0001, 8'h00};
    tbl[4] = '{2'd0, 8'hFF,  4'hF, 4'b1100, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_strobes", {28'd0, signal_load, signal_init, signal_neg, signal_oe}, 32'd0);
    chk("rst_data", {24'd0, data_in}, 32'd0);
    chk("rst_attr_busy", {27'd0, attr_in, busy}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);

    // Single-command table
    for (int i = 0; i < 5; i++) begin
      push_cmd(tbl[i].op, tbl[i].d, tbl[i].a);
      @(negedge clk);
      chk($sformatf("tbl%0d_sig", i), {28'd0, signal_load, signal_init, signal_neg, signal_oe}, {28'd0, tbl[i].e_sig});
      chk($sformatf("tbl%0d_data", i), {24'd0, data_in}, {24'd0, tbl[i].e_d});
      chk($sformatf("tbl%0d_attr", i), {28'd0, attr_in}, {28'd0, tbl[i].a});
      @(negedge clk);
      chk($sformatf("tbl%0d_after", i), {28'd0, signal_load, signal_init, signal_neg, 1'b0}, 32'd0);
      wait_idle();
    end

    // INIT 25, LOAD 25, READ back-to-back: pitch and busy timing
    t_init = -1; t_load = -1; t_oe = -1; t_oef = -1; t_bf = -1; d_init = '0; d_load = '0;
    for (int c = 0; c < 80; c++) begin
      if (signal_load && signal_init && t_init < 0) begin t_init = c; d_init = data_in; end
      if (signal_load && !signal_init && !signal_neg && t_load < 0) begin t_load = c; d_load = data_in; end
      if (signal_oe && t_oe < 0) t_oe = c;
      if (t_oe >= 0 && !signal_oe && t_oef < 0) t_oef = c;
      if (t_oef >= 0 && !busy && t_bf < 0) t_bf = c;
      cmd_valid = (c < 3);
      cmd_op    = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : 2'd3;
      cmd_data  = (c < 2) ? 8'd25 : 8'd0;
      cmd_attr  = 4'h3;
      @(negedge clk);
    end
    cmd_valid = 0;
    chk("seq_init_data", {24'd0, d_init}, 32'd25);
    chk("seq_load_data", {24'd0, d_load}, 32'd25);
    chk("seq_init_to_load", 32'(t_load - t_init), 32'd2);
    chk("seq_load_to_oe", 32'(t_oe - t_load), 32'(1 + SETTLE));
    chk("seq_oe_width", 32'(t_oef - t_oe), 32'(OE));
    chk("seq_busy_fall", 32'(t_bf - t_oef), 32'd1);
    wait_idle();

    // FIFO fills while the FSM sits in SETTLE; fifth push waits for a slot
    push_cmd(2'd1, 8'h11, 4'h0);
    @(negedge clk);
    want[0] = 8'h22; want[1] = 8'h33; want[2] = 8'h44; want[3] = 8'h66; want[4] = 8'h55;
    for (int i = 0; i < 4; i++) push_cmd(2'd1, want[i], 4'h1);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1; cmd_op = 2'd1; cmd_data = want[4]; cmd_attr = 4'h2;
    n = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int c = 0; c < 150 && n < 5; c++) begin
      acc = cmd_valid && cmd_ready;
      @(negedge clk);
      if (acc) cmd_valid = 0;
      if (signal_load) begin got[n] = data_in; n++; end
    end
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) chk($sformatf("order%0d", i), {24'd0, got[i]}, {24'd0, want[i]});
    wait_idle();

    // NEG 3 with attribute A; attribute holds until the next READ
    push_cmd(2'd2, 8'd3, 4'hA);
    @(negedge clk);
    chk("neg_sig", {28'd0, signal_load, signal_init, signal_neg, signal_oe}, 32'b1010);
    chk("neg_data", {24'd0, data_in}, 32'd3);
    chk("neg_attr", {28'd0, attr_in}, 32'hA);
    wait_idle();
    chk("attr_hold_idle", {28'd0, attr_in}, 32'hA);
    push_cmd(2'd3, 8'h99, 4'hA);
    @(negedge clk);
    chk("read_oe", 32'(signal_oe), 32'd1);
    chk("read_data_zero", {24'd0, data_in}, 32'd0);
    chk("read_attr", {28'd0, attr_in}, 32'hA);
    wait_idle();

    // Asynchronous reset during OUTPUT with a command still queued
    push_cmd(2'd3, 8'h00, 4'h5);
    repeat (3) @(negedge clk);
    push_cmd(2'd1, 8'h77, 4'h6);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_oe_async", 32'(signal_oe), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    chk("rst_attr_async", {28'd0, attr_in}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    chk("rst_ready_after", 32'(cmd_ready), 32'd1);
    any_strobe = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (signal_load || signal_oe || busy) any_strobe++;
    end
    chk("rst_queue_lost", 32'(any_strobe), 32'd0);

`ifdef BENCH_SEQ_STATS_EN
    for (int i = 0; i < 6; i++) push_cmd(2'd0, 8'(i), 4'h0);
    wait_idle();
    chk("issued_count", {16'd0, issued_count}, 32'd6);
`endif

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 8'($urandom);
      cmd_attr  = 4'($urandom);
      @(negedge clk);
    end
    cmd_valid = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
